decode_sb: RTL and testbench

Parametrised decode stage with a per-register scoreboard. Sits between fetch (IF/ID) and execute, and replaces fixed EX/M destination compares with per-register countdown counters. These counters track results from variable-latency producers: ALU, load, and the multi-cycle multiply pipe. Adds a valid/ready handshake, flush, WAW protection and a stall-cycle counter; ID/EX boundary registers remain inside the block.

---
 rtl/decode_sb_pkg.sv | 102 ++++++++++
 rtl/decode_sb_if.sv | 38 +++
 rtl/decode_sb_scoreboard.sv | 58 +++++
 rtl/decode_sb.sv | 170 +++++++++++++++++
 tb/tb_decode_sb.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_sb_pkg.sv
// ============================================================================
// Package  : decode_pkg
// Desc     : Opcode/funct constants, control struct and decode helpers shared
//            by the decode stage and its scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package decode_pkg;

  // Opcode field values (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_LB    = 6'h20;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SB    = 6'h28;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Funct field value (instr[5:0]) selecting the multiply pipe
  localparam logic [5:0] FN_MUL   = 6'h18;

  // Control bits carried across the ID/EX boundary
  typedef struct packed {
    logic regwrite;
    logic memtoreg;
    logic branch;
    logic memwrite;
    logic memread;
    logic byteword;
    logic alusrc;
  } ctrl_t;

  // Which producer pipe the result comes out of
  typedef enum logic [1:0] {
    LAT_ALU = 2'd0,
    LAT_LD  = 2'd1,
    LAT_MUL = 2'd2
  } lat_e;

  function automatic ctrl_t decode_ctrl(input logic [5:0] op);
    ctrl_t c;
    c = '0;
    case (op)
      OP_RTYPE: c.regwrite = 1'b1;
      OP_LW: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.memread  = 1'b1;
        c.alusrc   = 1'b1;
      end
      OP_LB: begin
        c.regwrite = 1'b1;
        c.memtoreg = 1'b1;
        c.memread  = 1'b1;
        c.alusrc   = 1'b1;
        c.byteword = 1'b1;
      end
      OP_SW: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
      end
      OP_SB: begin
        c.memwrite = 1'b1;
        c.alusrc   = 1'b1;
        c.byteword = 1'b1;
      end
      OP_BEQ:  c.branch = 1'b1;
      default: c = '0;
    endcase
    return c;
  endfunction

  // Jumps carry no register operands at all
  function automatic logic uses_src1(input logic [5:0] op);
    return (op != OP_JUMP);
  endfunction

  // Second operand: R-type ALU input, store data, branch comparand
  function automatic logic uses_src2(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_SW) || (op == OP_SB) || (op == OP_BEQ);
  endfunction

  function automatic logic is_writer(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_LB);
  endfunction

  function automatic lat_e lat_class(input logic [5:0] op, input logic [5:0] fn);
    lat_e l;
    if ((op == OP_RTYPE) && (fn == FN_MUL)) begin
      l = LAT_MUL;
    end else if ((op == OP_LW) || (op == OP_LB)) begin
      l = LAT_LD;
    end else begin
      l = LAT_ALU;
    end
    return l;
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_sb_if.sv
// ============================================================================
// Interface : decode_sb_if
// Desc      : IF/ID -> decode handshake bundle (valid/ready, flush, pc, instr)
// Revision  : 1.0 - initial release
// ============================================================================
`default_nettype none

interface decode_sb_if #(
  parameter int ADDR_SIZE  = 32,
  parameter int INSTR_SIZE = 32
) ();

  logic                  in_valid;
  logic                  in_ready;
  logic                  flush;
  logic [ADDR_SIZE-1:0]  pc;
  logic [INSTR_SIZE-1:0] instruction;

  // Fetch side drives the instruction, decode answers with ready
  modport master (
    output in_valid,
    output flush,
    output pc,
    output instruction,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  flush,
    input  pc,
    input  instruction,
    output in_ready
  );

endinterface

`default_nettype wire

// File: rtl/decode_sb_scoreboard.sv
// ============================================================================
// Module   : decode_scoreboard
// Desc     : Per-register countdown counters tracking in-flight results, plus
//            the RAW / WAW hazard compares against them.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_scoreboard #(
  parameter int REG_ADDR = 5,
  parameter int CNT_W    = 3
) (
  input  wire logic                clk,
  input  wire logic                reset,
  input  wire logic [REG_ADDR-1:0] src1,
  input  wire logic [REG_ADDR-1:0] src2,
  input  wire logic [REG_ADDR-1:0] dest,
  input  wire logic                use1,
  input  wire logic                use2,
  input  wire logic                writer,
  input  wire logic                load,
  input  wire logic [CNT_W-1:0]    lat,
  output logic                     raw,
  output logic                     waw
);

  localparam int c_nreg = 2 ** REG_ADDR;

  logic [CNT_W-1:0] r_cnt [c_nreg];

  // Count down every busy register; a new issue reloads its destination.
  // Entry 0 is never loaded, so it stays at its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_nreg; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int i = 1; i < c_nreg; i++) begin
        if (load && (dest == REG_ADDR'(i))) begin
          r_cnt[i] <= lat;
        end else if (r_cnt[i] != '0) begin
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
        end
      end
    end
  end

  // A source is busy while its counter is nonzero; a write must not finish
  // before an older, slower write to the same register.
  always_comb begin
    raw = (use1 && (r_cnt[src1] != '0)) || (use2 && (r_cnt[src2] != '0));
    waw = writer && (r_cnt[dest] > lat);
  end

endmodule

`default_nettype wire

// File: rtl/decode_sb.sv
// ============================================================================
// Module   : decode_sb
// Desc     : Decode stage with per-register scoreboard, valid/ready handshake,
//            flush, stall counter and the ID/EX boundary registers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_sb
  import decode_pkg::*;
#(
  parameter int ADDR_SIZE  = 32,
  parameter int INSTR_SIZE = 32,
  parameter int REG_SIZE   = 32,
  parameter int REG_ADDR   = 5,
  parameter int ALU_LAT    = 2,
  parameter int LD_LAT     = 3,
  parameter int MUL_LAT    = 5
) (
  input  wire logic                 clk,
  input  wire logic                 reset,
  decode_sb_if.slave                ifid,
  output logic [REG_ADDR-1:0]       src_reg1,
  output logic [REG_ADDR-1:0]       src_reg2,
  input  wire logic [REG_SIZE-1:0]  rin_reg1,
  input  wire logic [REG_SIZE-1:0]  rin_reg2,
  output logic                      out_valid,
  output logic [ADDR_SIZE-1:0]      out_pc,
  output logic [REG_SIZE-1:0]       rout_reg1,
  output logic [REG_SIZE-1:0]       rout_reg2,
  output logic [ADDR_SIZE-1:0]      mimmediat,
  output logic [REG_ADDR-1:0]       dest_reg,
  output logic [5:0]                op_code,
  output logic [5:0]                funct_code,
  output logic                      regwrite,
  output logic                      memtoreg,
  output logic                      branch,
  output logic                      memwrite,
  output logic                      memread,
  output logic                      byteword,
  output logic                      alusrc,
  output logic                      is_mult,
  output logic [ADDR_SIZE-1:0]      jump_addr,
  output logic                      is_jump,
  output logic [31:0]               stall_cycles
);

  localparam int                   c_cnt_w   = $clog2(MUL_LAT + 1);
  localparam logic [c_cnt_w-1:0]   c_alu_lat = c_cnt_w'(ALU_LAT);
  localparam logic [c_cnt_w-1:0]   c_ld_lat  = c_cnt_w'(LD_LAT);
  localparam logic [c_cnt_w-1:0]   c_mul_lat = c_cnt_w'(MUL_LAT);
  localparam logic [ADDR_SIZE-1:0] c_jmask   = ADDR_SIZE'(32'hF000_0000);

  logic [INSTR_SIZE-1:0] w_instr;
  logic [5:0]            w_op;
  logic [5:0]            w_fn;
  logic [REG_ADDR-1:0]   w_dest;
  logic [ADDR_SIZE-1:0]  w_imm;
  ctrl_t                 w_ctrl;
  logic                  w_use1;
  logic                  w_use2;
  logic                  w_writer;
  logic [c_cnt_w-1:0]    w_lat;
  logic                  w_raw;
  logic                  w_waw;
  logic                  w_live;
  logic                  w_stall;
  logic                  w_issue;
  logic                  w_load;

  assign w_instr  = ifid.instruction;
  assign w_op     = w_instr[31:26];
  assign w_fn     = w_instr[5:0];
  assign w_dest   = REG_ADDR'(w_instr[15:11]);
  assign w_imm    = {{(ADDR_SIZE-21){w_instr[20]}}, w_instr[20:0]};
  assign src_reg1 = REG_ADDR'(w_instr[25:21]);
  assign src_reg2 = REG_ADDR'(w_instr[20:16]);

  // Decode control, operand usage and producer latency for the IF/ID word
  always_comb begin
    w_ctrl   = decode_ctrl(w_op);
    w_use1   = uses_src1(w_op);
    w_use2   = uses_src2(w_op);
    w_writer = is_writer(w_op);
    case (lat_class(w_op, w_fn))
      LAT_LD:  w_lat = c_ld_lat;
      LAT_MUL: w_lat = c_mul_lat;
      default: w_lat = c_alu_lat;
    endcase
  end

  decode_scoreboard #(
    .REG_ADDR (REG_ADDR),
    .CNT_W    (c_cnt_w)
  ) u_scoreboard (
    .clk    (clk),
    .reset  (reset),
    .src1   (src_reg1),
    .src2   (src_reg2),
    .dest   (w_dest),
    .use1   (w_use1),
    .use2   (w_use2),
    .writer (w_writer),
    .load   (w_load),
    .lat    (w_lat),
    .raw    (w_raw),
    .waw    (w_waw)
  );

  // Flush kills the instruction outright, so it can neither stall nor issue
  assign w_live        = ifid.in_valid && !ifid.flush;
  assign w_stall       = w_live && (w_raw || w_waw);
  assign w_issue       = w_live && !w_stall;
  assign w_load        = w_issue && w_writer && (w_dest != '0);
  assign ifid.in_ready = !w_stall;

  assign jump_addr = (ifid.pc & c_jmask) | ADDR_SIZE'({w_instr[25:0], 2'b00});
  assign is_jump   = w_live && (w_op == OP_JUMP);

  // ID/EX boundary: data always follows the inputs, control only on issue
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      rout_reg1  <= '0;
      rout_reg2  <= '0;
      mimmediat  <= '0;
      dest_reg   <= '0;
      op_code    <= '0;
      funct_code <= '0;
      regwrite   <= 1'b0;
      memtoreg   <= 1'b0;
      branch     <= 1'b0;
      memwrite   <= 1'b0;
      memread    <= 1'b0;
      byteword   <= 1'b0;
      alusrc     <= 1'b0;
      is_mult    <= 1'b0;
    end else begin
      out_valid  <= w_issue;
      out_pc     <= ifid.pc;
      rout_reg1  <= rin_reg1;
      rout_reg2  <= rin_reg2;
      mimmediat  <= w_imm;
      dest_reg   <= w_dest;
      op_code    <= w_op;
      funct_code <= w_fn;
      regwrite   <= w_issue && w_ctrl.regwrite;
      memtoreg   <= w_issue && w_ctrl.memtoreg;
      branch     <= w_issue && w_ctrl.branch;
      memwrite   <= w_issue && w_ctrl.memwrite;
      memread    <= w_issue && w_ctrl.memread;
      byteword   <= w_issue && w_ctrl.byteword;
      alusrc     <= w_issue && w_ctrl.alusrc;
      is_mult    <= w_issue && (w_op == OP_RTYPE) && (w_fn == FN_MUL);
    end
  end

  // Saturating count of cycles spent holding IF/ID
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cycles <= '0;
    end else if (w_stall && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_decode_sb.sv
// ============================================================================
// Module   : tb_decode_sb
// Desc     : Self-checking bench for decode_sb using a ready-time model of the
//            register file results.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_decode_sb;
  import decode_pkg::*;

  localparam int ALU_L = 2;
  localparam int LD_L  = 3;
  localparam int MUL_L = 5;
  localparam logic [5:0] FN_ADD = 6'h20;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  src_reg1, src_reg2, dest_reg;
  logic [31:0] rin_reg1, rin_reg2;
  logic        out_valid;
  logic [31:0] out_pc, rout_reg1, rout_reg2, mimmediat, jump_addr, stall_cycles;
  logic [5:0]  op_code, funct_code;
  logic        regwrite, memtoreg, branch, memwrite, memread, byteword, alusrc;
  logic        is_mult, is_jump;

  always #5 clk = ~clk;

  decode_sb_if #(.ADDR_SIZE(32), .INSTR_SIZE(32)) ifid ();

  decode_sb #(
    .ADDR_SIZE(32), .INSTR_SIZE(32), .REG_SIZE(32), .REG_ADDR(5),
    .ALU_LAT(ALU_L), .LD_LAT(LD_L), .MUL_LAT(MUL_L)
  ) dut (
    .clk(clk), .reset(reset), .ifid(ifid),
    .src_reg1(src_reg1), .src_reg2(src_reg2),
    .rin_reg1(rin_reg1), .rin_reg2(rin_reg2),
    .out_valid(out_valid), .out_pc(out_pc),
    .rout_reg1(rout_reg1), .rout_reg2(rout_reg2), .mimmediat(mimmediat),
    .dest_reg(dest_reg), .op_code(op_code), .funct_code(funct_code),
    .regwrite(regwrite), .memtoreg(memtoreg), .branch(branch),
    .memwrite(memwrite), .memread(memread), .byteword(byteword),
    .alusrc(alusrc), .is_mult(is_mult), .jump_addr(jump_addr),
    .is_jump(is_jump), .stall_cycles(stall_cycles)
  );

  int checks = 0;
  int errors = 0;

  // Model: absolute edge number at which each register's value becomes readable
  int ready_at [32];
  int k = 0;
  int stall_model = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input int rs, input int rt, input int rd, input logic [5:0] fn);
    return {OP_RTYPE, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
  endfunction

  function automatic int remaining(input int r);
    int d;
    d = ready_at[r] - k;
    return (r == 0 || d < 0) ? 0 : d;
  endfunction

  function automatic int lat_of(input logic [5:0] op, input logic [5:0] fn);
    if (op == OP_RTYPE && fn == FN_MUL) return MUL_L;
    if (op == OP_LW || op == OP_LB) return LD_L;
    return ALU_L;
  endfunction

  // {regwrite, memtoreg, branch, memwrite, memread, byteword, alusrc}
  function automatic logic [6:0] ctl_of(input logic [5:0] op);
    logic ld, st;
    ld = (op == OP_LW) || (op == OP_LB);
    st = (op == OP_SW) || (op == OP_SB);
    return {(op == OP_RTYPE) || ld, ld, op == OP_BEQ, st, ld,
            (op == OP_LB) || (op == OP_SB), ld || st};
  endfunction

  // One cycle: drive at posedge+1, check comb at negedge, check regs at posedge+1
  task automatic step(input logic v, input logic fl, input logic [31:0] ins,
                      input logic [31:0] p, output logic issued);
    logic [5:0]  op, fn;
    int          s1, s2, d, lat;
    logic        u1, u2, wr, hz, st, iss;
    logic [31:0] r1, r2;
    op = ins[31:26]; fn = ins[5:0];
    s1 = int'(ins[25:21]); s2 = int'(ins[20:16]); d = int'(ins[15:11]);
    r1 = $urandom; r2 = $urandom;
    ifid.in_valid = v; ifid.flush = fl; ifid.instruction = ins; ifid.pc = p;
    rin_reg1 = r1; rin_reg2 = r2;
    u1  = (op != OP_JUMP);
    u2  = (op == OP_RTYPE) || (op == OP_SW) || (op == OP_SB) || (op == OP_BEQ);
    wr  = (op == OP_RTYPE) || (op == OP_LW) || (op == OP_LB);
    lat = lat_of(op, fn);
    hz  = (u1 && remaining(s1) > 0) || (u2 && remaining(s2) > 0) || (wr && remaining(d) > lat);
    st  = v && !fl && hz;
    iss = v && !fl && !hz;
    @(negedge clk);
    chk("in_ready", ifid.in_ready, !st);
    chk("is_jump", is_jump, v && !fl && op == OP_JUMP);
    chk("jump_addr", jump_addr, {p[31:28], ins[25:0], 2'b00});
    chk("src_reg1", src_reg1, ins[25:21]);
    chk("src_reg2", src_reg2, ins[20:16]);
    @(posedge clk);
    #1;
    k++;
    if (st) stall_model++;
    if (iss && wr && d != 0) ready_at[d] = k + lat;
    chk("out_valid", out_valid, iss);
    chk("ctrl", {regwrite, memtoreg, branch, memwrite, memread, byteword, alusrc},
        iss ? ctl_of(op) : 7'd0);
    chk("is_mult", is_mult, iss && op == OP_RTYPE && fn == FN_MUL);
    chk("dest_reg", dest_reg, ins[15:11]);
    chk("out_pc", out_pc, p);
    chk("rout_reg1", rout_reg1, r1);
    chk("rout_reg2", rout_reg2, r2);
    chk("mimmediat", mimmediat, {{11{ins[20]}}, ins[20:0]});
    chk("op_funct", {op_code, funct_code}, {op, fn});
    chk("stall_cycles", stall_cycles, 32'(stall_model));
    issued = iss;
  endtask

  // Hold an instruction in IF/ID until it issues; report the stall count
  task automatic issue_instr(input logic [31:0] ins, input logic [31:0] p, output int stalls);
    logic iss;
    iss = 1'b0;
    stalls = 0;
    for (int t = 0; t < 20 && !iss; t++) begin
      step(1'b1, 1'b0, ins, p, iss);
      if (!iss) stalls++;
    end
    checks++;
    assert (iss) else begin
      errors++;
      $error("FAIL issue_timeout: observed=%0d expected=issue within 20", stalls);
    end
  endtask

  task automatic idle(input int n);
    logic iss;
    for (int t = 0; t < n; t++) step(1'b0, 1'b0, 32'd0, 32'd0, iss);
  endtask

  // Asynchronous reset mid-cycle, checked before any clock edge
  task automatic do_reset();
    ifid.in_valid = 1'b0; ifid.flush = 1'b0;
    reset = 1'b0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ctrl", {regwrite, memtoreg, branch, memwrite, memread, byteword, alusrc, is_mult}, 8'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_data", {out_pc, rout_reg1}, 64'd0);
    chk("rst_imm", mimmediat, 32'd0);
    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    stall_model = 0;
    @(posedge clk);
    k++;
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int          st;
    logic        iss;
    logic [31:0] ins;
    logic [5:0]  rop;
    logic        v, fl, hold;

    for (int r = 0; r < 32; r++) ready_at[r] = 0;
    reset = 1'b0;
    ifid.in_valid = 1'b0; ifid.flush = 1'b0; ifid.pc = '0; ifid.instruction = '0;
    rin_reg1 = '0; rin_reg2 = '0;
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_ctrl", {regwrite, memtoreg, branch, memwrite, memread, byteword, alusrc, is_mult}, 8'd0);
    chk("rst_stall_cycles", stall_cycles, 32'd0);
    chk("rst_data", {out_pc, rout_reg2}, 64'd0);
    @(posedge clk); @(posedge clk); k += 2;
    #1;
    reset = 1'b1;

    // RAW on an ALU result
    issue_instr(rtype(1, 2, 3, FN_ADD), 32'h100, st);
    chk("raw_producer_stalls", st, 0);
    issue_instr(rtype(3, 1, 5, FN_ADD), 32'h104, st);
    chk("raw_stalls", st, 2);
    chk("raw_stall_cycles", stall_cycles, 32'd2);
    idle(6);

    // Dependent on a multiply
    issue_instr(rtype(1, 2, 4, FN_MUL), 32'h200, st);
    chk("mul_is_mult", is_mult, 1'b1);
    issue_instr(rtype(4, 0, 5, FN_ADD), 32'h204, st);
    chk("mul_dep_stalls", st, 5);
    idle(6);

    // WAW: fast write behind a slow one to the same register
    issue_instr(rtype(1, 2, 6, FN_MUL), 32'h300, st);
    issue_instr(rtype(1, 2, 6, FN_ADD), 32'h304, st);
    chk("waw_stalls", st, 3);
    idle(6);

    // r0 is never busy
    issue_instr(rtype(1, 2, 0, FN_ADD), 32'h400, st);
    issue_instr(rtype(0, 0, 7, FN_ADD), 32'h404, st);
    chk("r0_stalls", st, 0);
    idle(6);

    // Flush over a stalled dependent; the counter keeps running
    issue_instr(rtype(1, 2, 3, FN_ADD), 32'h500, st);
    step(1'b1, 1'b1, rtype(3, 1, 5, FN_ADD), 32'h504, iss);
    chk("flush_no_issue", iss, 1'b0);
    issue_instr(rtype(3, 1, 5, FN_ADD), 32'h504, st);
    chk("flush_then_stalls", st, 1);
    idle(6);

    // Jump target formation
    ifid.in_valid = 1'b1; ifid.flush = 1'b0;
    ifid.pc = 32'h4000_0010; ifid.instruction = {OP_JUMP, 26'h100};
    @(negedge clk);
    chk("jump_addr_const", jump_addr, 32'h4000_0400);
    chk("jump_is_jump", is_jump, 1'b1);
    ifid.in_valid = 1'b0;
    #1;
    chk("jump_invalid", is_jump, 1'b0);
    @(posedge clk);
    k++;
    #1;

    // Reset while a multiply is outstanding
    issue_instr(rtype(1, 2, 4, FN_MUL), 32'h600, st);
    idle(1);
    do_reset();
    issue_instr(rtype(4, 4, 5, FN_ADD), 32'h604, st);
    chk("post_reset_stalls", st, 0);

    // Randomized traffic on a small register window to provoke hazards
    hold = 1'b0;
    ins  = '0;
    for (int n = 0; n < 400; n++) begin
      v  = ($urandom_range(0, 9) != 0);
      fl = ($urandom_range(0, 9) == 0);
      if (!hold) begin
        case ($urandom_range(0, 7))
          0: ins = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), FN_ADD);
          1: ins = rtype($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7), FN_MUL);
          7: ins = {OP_JUMP, 26'($urandom)};
          default: begin
            case ($urandom_range(0, 4))
              0: rop = OP_LW;
              1: rop = OP_LB;
              2: rop = OP_SW;
              3: rop = OP_SB;
              default: rop = OP_BEQ;
            endcase
            ins = {rop, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 11'($urandom)};
          end
        endcase
      end
      step(v, fl, ins, $urandom, iss);
      hold = v && !fl && !iss;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
